// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the instruction-fetch stage:
// datapath width, the NOP bubble word and the fetch FSM encoding.
`timescale 1ns/1ps
package fetch_stage_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps one request outstanding to a
// variable-latency instruction memory and holds the returned word for IF/ID.
//
// state  | meaning
// S_REQ  | no request outstanding; request PC when the buffer has room
// S_WAIT | request granted, waiting for its response
// S_DROP | request granted but squashed by a redirect; discard its response
`timescale 1ns/1ps
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pcF,
  output logic [31:0] pc_plus_fourF,
  output logic [31:0] instrF,
  output logic        validF
);
  import fetch_stage_pkg::*;

  fetch_state_e state;
  fetch_state_e state_nxt;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] buf_pc;
  logic [XLEN-1:0] buf_pc4;
  logic [XLEN-1:0] buf_instr;
  logic            buf_valid;
  logic            run;
  logic            fire;
  logic            consume;
  logic            fill;

  assign pc_plus4 = pc + 32'd4;
  assign fire     = imem_req & imem_gnt;
  assign consume  = buf_valid & ~StallF;
  assign fill     = (state == S_WAIT) & imem_rvalid & ~PCSrcE;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_REQ;
    end else begin
      state <= state_nxt;
    end
  end

  // A redirect only changes where the FSM goes when a request is in flight.
  always_comb begin
    state_nxt = state;
    case (state)
      S_REQ: begin
        if (fire) state_nxt = PCSrcE ? S_DROP : S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid)  state_nxt = S_REQ;
        else if (PCSrcE)  state_nxt = S_DROP;
      end
      S_DROP: begin
        if (imem_rvalid) state_nxt = S_REQ;
      end
      default: state_nxt = S_REQ;
    endcase
  end

  // run keeps imem_req low while reset is held and for the release cycle.
  always_comb begin
    imem_req = run & (state == S_REQ) & (~buf_valid | ~StallF);
    instrF   = buf_valid ? buf_instr : NOP_INSTR;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run       <= 1'b0;
      pc        <= RESET_PC;
      buf_valid <= 1'b0;
      buf_pc    <= '0;
      buf_pc4   <= '0;
      buf_instr <= NOP_INSTR;
    end else begin
      run <= 1'b1;
      if (PCSrcE) begin
        pc        <= {PCTargetE[31:2], 2'b00};
        buf_valid <= 1'b0;
      end else if (fill) begin
        pc        <= pc_plus4;
        buf_pc    <= pc;
        buf_pc4   <= pc_plus4;
        buf_instr <= imem_rdata;
        buf_valid <= 1'b1;
      end else if (consume) begin
        buf_valid <= 1'b0;
      end
    end
  end

  assign imem_addr     = pc;
  assign pcF           = buf_pc;
  assign pc_plus_fourF = buf_pc4;
  assign validF        = buf_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed cycle table, reset corner cases, a
// wrap-around instance and a randomized run against a program-order model.
`timescale 1ns/1ps
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        pcsrc = 1'b0;
  logic [31:0] target = '0;
  logic        gnt_en = 1'b1;
  int          lat = 1;

  logic        req, gnt, rvalid, valid;
  logic [31:0] addr, rdata, pc_f, pc4_f, instr_f;

  logic        rst2_n = 1'b0;
  logic        zero = 1'b0;
  logic [31:0] zero32 = '0;
  logic        req2, valid2, pend2 = 1'b0;
  logic [31:0] addr2, rdata2, pc_f2, pc4_f2, instr_f2, paddr2 = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  fetch_stage dut (
    .clk(clk), .reset(rst_n), .StallF(stall), .PCSrcE(pcsrc), .PCTargetE(target),
    .imem_req(req), .imem_addr(addr), .imem_gnt(gnt), .imem_rvalid(rvalid),
    .imem_rdata(rdata), .pcF(pc_f), .pc_plus_fourF(pc4_f), .instrF(instr_f),
    .validF(valid)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(rst2_n), .StallF(zero), .PCSrcE(zero), .PCTargetE(zero32),
    .imem_req(req2), .imem_addr(addr2), .imem_gnt(1'b1), .imem_rvalid(pend2),
    .imem_rdata(rdata2), .pcF(pc_f2), .pc_plus_fourF(pc4_f2), .instrF(instr_f2),
    .validF(valid2)
  );

  // Memory: grants per gnt_en, answers a granted request after lat cycles.
  logic        pend = 1'b0;
  int          cnt = 0;
  logic [31:0] paddr = '0;
  assign gnt    = gnt_en;
  assign rvalid = pend && (cnt == 0);
  assign rdata  = word(paddr);

  always @(posedge clk) begin
    if (pend) begin
      if (cnt == 0) pend <= 1'b0;
      else cnt <= cnt - 1;
    end
    if (req && gnt) begin
      pend  <= 1'b1;
      cnt   <= lat - 1;
      paddr <= addr;
    end
  end

  assign rdata2 = word(paddr2);
  always @(posedge clk) begin
    pend2 <= req2;
    if (req2) paddr2 <= addr2;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        stall;
    logic        pcsrc;
    logic [31:0] target;
    int          lat;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic p, input logic [31:0] t, input int l,
                              input logic r, input logic [31:0] a, input logic v,
                              input logic [31:0] pc);
    vec_t x;
    x.stall = s; x.pcsrc = p; x.target = t; x.lat = l;
    x.e_req = r; x.e_addr = a; x.e_valid = v; x.e_pc = pc;
    return x;
  endfunction

  vec_t vecs[24];

  initial begin
    logic [31:0] exp_next, hold_pc, hold_instr;
    logic        was_redirect, was_hold;
    int          consumed;

    vecs[0]  = mk(0, 0, 0,        1, 0, 32'h000, 0, 0);
    vecs[1]  = mk(0, 0, 0,        1, 1, 32'h000, 0, 0);
    vecs[2]  = mk(0, 0, 0,        1, 0, 32'h000, 0, 0);
    vecs[3]  = mk(0, 0, 0,        1, 1, 32'h004, 1, 32'h000);
    vecs[4]  = mk(0, 0, 0,        1, 0, 32'h004, 0, 0);
    vecs[5]  = mk(0, 0, 0,        1, 1, 32'h008, 1, 32'h004);
    vecs[6]  = mk(0, 0, 0,        1, 0, 32'h008, 0, 0);
    vecs[7]  = mk(1, 0, 0,        1, 0, 32'h00C, 1, 32'h008);
    vecs[8]  = mk(1, 0, 0,        1, 0, 32'h00C, 1, 32'h008);
    vecs[9]  = mk(1, 0, 0,        1, 0, 32'h00C, 1, 32'h008);
    vecs[10] = mk(1, 0, 0,        1, 0, 32'h00C, 1, 32'h008);
    vecs[11] = mk(0, 0, 0,        1, 1, 32'h00C, 1, 32'h008);
    vecs[12] = mk(0, 0, 0,        1, 0, 32'h00C, 0, 0);
    vecs[13] = mk(0, 0, 0,        3, 1, 32'h010, 1, 32'h00C);
    vecs[14] = mk(0, 1, 32'h103,  1, 0, 32'h010, 0, 0);
    vecs[15] = mk(0, 0, 0,        1, 0, 32'h100, 0, 0);
    vecs[16] = mk(0, 0, 0,        1, 0, 32'h100, 0, 0);
    vecs[17] = mk(0, 0, 0,        1, 1, 32'h100, 0, 0);
    vecs[18] = mk(0, 0, 0,        1, 0, 32'h100, 0, 0);
    vecs[19] = mk(0, 0, 0,        1, 1, 32'h104, 1, 32'h100);
    vecs[20] = mk(0, 1, 32'h200,  1, 0, 32'h104, 0, 0);
    vecs[21] = mk(0, 0, 0,        1, 1, 32'h200, 0, 0);
    vecs[22] = mk(0, 0, 0,        1, 0, 32'h200, 0, 0);
    vecs[23] = mk(0, 0, 0,        3, 1, 32'h204, 1, 32'h200);

    // Reset state of both instances.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {31'b0, req}, 0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_valid", {31'b0, valid}, 0);
    chk("rst_pcF", pc_f, 0);
    chk("rst_pc4", pc4_f, 0);
    chk("rst_instr", instr_f, NOP);
    chk("rst_wrap_addr", addr2, 32'hFFFF_FFFC);
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      stall = vecs[i].stall; pcsrc = vecs[i].pcsrc; target = vecs[i].target; lat = vecs[i].lat;
      #1;
      chk($sformatf("v%0d_req", i), {31'b0, req}, {31'b0, vecs[i].e_req});
      chk($sformatf("v%0d_addr", i), addr, vecs[i].e_addr);
      chk($sformatf("v%0d_valid", i), {31'b0, valid}, {31'b0, vecs[i].e_valid});
      if (vecs[i].e_valid) begin
        chk($sformatf("v%0d_pcF", i), pc_f, vecs[i].e_pc);
        chk($sformatf("v%0d_pc4", i), pc4_f, vecs[i].e_pc + 32'd4);
        chk($sformatf("v%0d_instr", i), instr_f, word(vecs[i].e_pc));
      end else begin
        chk($sformatf("v%0d_instr", i), instr_f, NOP);
      end
      @(negedge clk);
    end
    stall = 0; pcsrc = 0; lat = 1;

    // Reset while waiting; the stale response must be ignored afterwards.
    gnt_en = 0;
    #2 rst_n = 1'b0;
    #2;
    chk("rw_req", {31'b0, req}, 0);
    chk("rw_addr", addr, 32'h0);
    chk("rw_instr", instr_f, NOP);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rw_rel_req", {31'b0, req}, 0);
    @(negedge clk);
    #1;
    chk("rw_stale_req", {31'b0, req}, 1);
    chk("rw_stale_valid", {31'b0, valid}, 0);
    @(negedge clk);
    #1;
    chk("rw_after_req", {31'b0, req}, 1);
    chk("rw_after_addr", addr, 32'h0);
    chk("rw_after_valid", {31'b0, valid}, 0);
    chk("rw_after_instr", instr_f, NOP);
    gnt_en = 1;
    @(negedge clk);
    #1 chk("rw_wait_req", {31'b0, req}, 0);
    @(negedge clk);
    #1;
    chk("rw_first_valid", {31'b0, valid}, 1);
    chk("rw_first_pcF", pc_f, 32'h0);
    chk("rw_first_instr", instr_f, word(32'h0));
    @(negedge clk);
    gnt_en = 0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized run checked against program order.
    exp_next = 32'h0;
    was_redirect = 0; was_hold = 0; consumed = 0;
    hold_pc = '0; hold_instr = '0;
    for (int k = 0; k < 800; k++) begin
      if (was_redirect) chk("rnd_redirect_flush", {31'b0, valid}, 0);
      if (was_hold) begin
        chk("rnd_hold_valid", {31'b0, valid}, 1);
        chk("rnd_hold_pcF", pc_f, hold_pc);
        chk("rnd_hold_instr", instr_f, hold_instr);
      end
      stall  = ($urandom_range(9, 0) < 3);
      pcsrc  = ($urandom_range(19, 0) == 0);
      target = $urandom;
      gnt_en = ($urandom_range(9, 0) < 7);
      lat    = $urandom_range(3, 1);
      #1;
      if (valid) begin
        chk("rnd_instr", instr_f, word(pc_f));
        chk("rnd_pc4", pc4_f, pc_f + 32'd4);
      end else begin
        chk("rnd_nop", instr_f, NOP);
      end
      if (k > 0) chk("rnd_req", {31'b0, req}, {31'b0, !pend && (!valid || !stall)});
      was_redirect = pcsrc;
      was_hold     = valid && stall && !pcsrc;
      hold_pc      = pc_f;
      hold_instr   = instr_f;
      if (pcsrc) begin
        exp_next = {target[31:2], 2'b00};
      end else if (valid && !stall) begin
        chk("rnd_order_pc", pc_f, exp_next);
        exp_next = exp_next + 32'd4;
        consumed++;
      end
      @(negedge clk);
    end
    stall = 0; pcsrc = 0;
    chk("rnd_progress", {31'b0, consumed >= 40}, 1);

    // PC wrap from the top of the address space.
    rst2_n = 1'b1;
    #1 chk("wrap_idle_req", {31'b0, req2}, 0);
    @(negedge clk);
    #1;
    chk("wrap_req0", {31'b0, req2}, 1);
    chk("wrap_addr0", addr2, 32'hFFFF_FFFC);
    repeat (2) @(negedge clk);
    #1;
    chk("wrap_valid", {31'b0, valid2}, 1);
    chk("wrap_pcF", pc_f2, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc4_f2, 32'h0);
    chk("wrap_instr", instr_f2, word(32'hFFFF_FFFC));
    chk("wrap_req1", {31'b0, req2}, 1);
    chk("wrap_addr1", addr2, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage RISC-V pipeline, directly upstream of the IF/ID register.
- Owns the PC and issues one request at a time to a variable-latency instruction memory (req/gnt, rvalid).
- Holds the returned word in a one-entry output buffer. Drives pcF, pc_plus_fourF and instrF to IF/ID; instrF carries a NOP bubble when nothing valid is buffered.
- Honours StallF from the hazard unit and branch/jump redirects (PCSrcE/PCTargetE) from execute.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INSTR, 32'h0000_0013 (addi x0,x0,0), instrF value when no valid instruction is buffered.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- StallF  in  1  hazard unit: hold the buffered instruction; IF/ID does not capture.
- PCSrcE  in  1  execute redirect request.
- PCTargetE  in  32  redirect target; bits [1:0] forced to 0.
- imem_req  out  1  memory request valid.
- imem_addr  out  32  request address (word aligned).
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response data valid (one per granted request, in order).
- imem_rdata  in  32  response word.
- pcF  out  32  PC of the buffered instruction.
- pc_plus_fourF  out  32  pcF + 4, modulo 2^32.
- instrF  out  32  buffered instruction, or NOP_INSTR.
- validF  out  1  buffer holds a real instruction.

Behaviour:
- Reset (async, reset==0):
  - state=S_REQ, PC=RESET_PC, buffer invalid.
  - Outputs: pcF=0, pc_plus_fourF=0, instrF=NOP_INSTR, validF=0, imem_req=0, imem_addr=RESET_PC.
- States:
  - S_REQ: imem_req=1 iff the buffer is empty, or the buffer is valid and StallF==0 (consumed this edge).
    - imem_addr = PC.
    - On imem_req & imem_gnt: go to S_WAIT.
  - S_WAIT: imem_req=0.
    - On imem_rvalid: buffer <= {PC, PC+4, imem_rdata}, validF <= 1, PC <= PC+4, go to S_REQ.
  - S_DROP: imem_req=0.
    - On imem_rvalid: discard the response, go to S_REQ.
- Consumption: when validF=1 and StallF=0, IF/ID captures at the edge.
  - The buffer becomes invalid unless refilled at the same edge.
- StallF=1: buffer contents and outputs are held. An in-flight response still completes; the request rule guarantees the buffer has room.
- imem_rvalid in S_REQ is ignored (stale response after reset).
- Redirect (PCSrcE=1) has priority over StallF and all other events:
  - PC <= PCTargetE & ~3; buffer invalidated (instrF=NOP_INSTR next cycle).
  - In S_REQ without a grant this cycle: stay in S_REQ (new address next cycle).
  - In S_REQ with a grant this cycle: the old-address request is in flight; go to S_DROP.
  - In S_WAIT without rvalid: go to S_DROP.
  - In S_WAIT with rvalid: discard the response, go to S_REQ.
  - In S_DROP: update PC, stay in S_DROP unless rvalid arrives (then go to S_REQ).
- Throughput: at most one instruction per 2 cycles (grant cycle + response cycle, minimum memory latency 1). Only one outstanding request.
- PC arithmetic: 32-bit wrap; 32'hFFFF_FFFC + 4 = 0.
- All outputs are registered or decoded from the state register. imem_req has a combinational dependence on StallF only.

Decomposition:
- Shared pipeline package holds:
  - NOP_INSTR constant.
  - 2-bit fetch state encoding (S_REQ=0, S_WAIT=1, S_DROP=2).
  - XLEN=32.
- No sub-module: PC register, FSM and one-entry buffer stay in one file.

Test Plan:
- Reset release, memory returning PC-indexed words with 1-cycle latency, StallF=0 -> requests at 0x0, 0x4, 0x8. pcF/instrF update every 2 cycles; pc_plus_fourF=pcF+4; validF=1 after the first response.
- StallF=1 for 4 cycles while buffer holds pc 0x8 -> outputs frozen at 0x8. The next request (0xC) is issued only after StallF drops; no instruction is lost or duplicated.
- PCSrcE=1, PCTargetE=0x103 while in S_WAIT, rvalid 3 cycles later -> that response is dropped. The next request address is 0x100; validF=0 and instrF=0x13 until the 0x100 word returns.
- PCSrcE=1 in the same cycle as imem_rvalid -> response discarded, next imem_addr=target, validF=0.
- RESET_PC=32'hFFFF_FFFC -> first instruction pcF=0xFFFFFFFC with pc_plus_fourF=0; second request address is 0x0.
- Assert reset while in S_WAIT, release, then a stale rvalid arrives -> rvalid ignored; state S_REQ, PC=RESET_PC, instrF=NOP_INSTR.
